// File: rtl/mips_pkg.sv
// Shared types and constants for the decode-stage hazard logic.
// The hazard state is the pair {load timer running, mult/div timer running}.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_MD_WAIT    = 2'b01,
        ST_LD_WAIT    = 2'b10,
        ST_LD_MD_WAIT = 2'b11
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter that stops at zero; clear beats load beats decrement.
// Reports whether the count will be zero after the next clock edge.
module countdown_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         next_zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign next_zero_o = (count_d == '0);

endmodule

// File: rtl/id_hazard_controller.sv
// Decode-stage stall/flush sequencer: load-use and mult/div HI/LO hazards,
// taken-branch flush, and a saturating count of hazard stall cycles.
module id_hazard_controller
    import mips_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MD_LATENCY      = 4,
    parameter int CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic             i_id_hilo_read,
    input  logic             i_md_start,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_branch_taken,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [1:0]       o_dbg_state
);

    localparam int LD_W = $clog2(LOAD_USE_CYCLES + 1);
    localparam int MD_W = $clog2(MD_LATENCY + 1);
    localparam logic [LD_W-1:0] LD_RELOAD = LD_W'(LOAD_USE_CYCLES - 1);
    // The issue cycle is the first busy cycle, so the timer covers the rest.
    localparam logic [MD_W-1:0] MD_RELOAD = MD_W'(MD_LATENCY - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_hit, rt_hit, ld_hz, md_hz, stall;
    logic ld_running, md_busy, ld_load, md_issue;
    logic ld_next_zero, md_next_zero;

    assign ld_running = (state_q == ST_LD_WAIT) || (state_q == ST_LD_MD_WAIT);
    assign md_busy    = (state_q == ST_MD_WAIT) || (state_q == ST_LD_MD_WAIT);

    assign rs_hit = i_id_uses_rs && (i_id_rs == i_ex_rt);
    assign rt_hit = i_id_uses_rt && (i_id_rt == i_ex_rt);
    assign ld_hz  = i_id_valid && i_ex_mem_read && (i_ex_rt != REG_ZERO) && (rs_hit || rt_hit);
    assign md_hz  = i_id_valid && md_busy && (i_id_hilo_read || i_md_start);

    // A taken branch squashes ID, so its hazards never stall.
    assign stall    = !i_branch_taken && (ld_hz || md_hz || ld_running);
    assign ld_load  = ld_hz && !ld_running && !i_branch_taken;
    assign md_issue = i_id_valid && i_md_start && !stall && !i_branch_taken;

    countdown_timer #(.W(LD_W)) u_ld_timer (
        .clk_i       (i_clk),
        .rst_ni      (i_reset),
        .clear_i     (i_branch_taken),
        .load_i      (ld_load),
        .load_val_i  (LD_RELOAD),
        .next_zero_o (ld_next_zero)
    );

    countdown_timer #(.W(MD_W)) u_md_timer (
        .clk_i       (i_clk),
        .rst_ni      (i_reset),
        .clear_i     (1'b0),
        .load_i      (md_issue),
        .load_val_i  (MD_RELOAD),
        .next_zero_o (md_next_zero)
    );

    always_comb begin
        state_d       = hz_state_e'({!ld_next_zero, !md_next_zero});
        o_pc_en       = 1'b1;
        o_ifid_en     = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        if (!i_reset) begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
        end else if (i_branch_taken) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (stall) begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_md_busy   = i_reset && md_busy;
    assign o_stall_cnt = stall_cnt_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Bench for id_hazard_controller: a default instance plus a LOAD_USE_CYCLES=3,
// CNT_W=4 instance sharing the same stimulus.
module tb_id_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, uses_rs, uses_rt, hilo_read, md_start, ex_mem_read, branch_taken;
    logic [4:0] id_rs, id_rt, ex_rt;

    logic        pc_en, ifid_en, ifid_flush, idex_bubble, md_busy;
    logic [15:0] stall_cnt;
    logic [1:0]  dbg_state;
    logic        pc_en2, ifid_en2, ifid_flush2, idex_bubble2, md_busy2;
    logic [3:0]  stall_cnt2;
    logic [1:0]  dbg_state2;

    logic [4:0]  obs, obs2;
    logic [4:0]  exp_q[$];
    logic [15:0] cnt_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign obs  = {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy};
    assign obs2 = {pc_en2, ifid_en2, ifid_flush2, idex_bubble2, md_busy2};

    always #5 clk = ~clk;

    id_hazard_controller u_dut (
        .i_clk(clk), .i_reset(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_id_hilo_read(hilo_read),
        .i_md_start(md_start), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
        .i_branch_taken(branch_taken), .o_pc_en(pc_en), .o_ifid_en(ifid_en),
        .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble), .o_md_busy(md_busy),
        .o_stall_cnt(stall_cnt), .o_dbg_state(dbg_state)
    );

    id_hazard_controller #(.LOAD_USE_CYCLES(3), .MD_LATENCY(4), .CNT_W(4)) u_dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_id_hilo_read(hilo_read),
        .i_md_start(md_start), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
        .i_branch_taken(branch_taken), .o_pc_en(pc_en2), .o_ifid_en(ifid_en2),
        .o_ifid_flush(ifid_flush2), .o_idex_bubble(idex_bubble2), .o_md_busy(md_busy2),
        .o_stall_cnt(stall_cnt2), .o_dbg_state(dbg_state2)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
        hilo_read = 1'b0; md_start = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        branch_taken = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt,
                          input logic mr, input logic [4:0] ert);
        id_valid = v; id_rs = rs; uses_rs = urs; id_rt = rt; uses_rt = urt;
        ex_mem_read = mr; ex_rt = ert;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        logic [4:0] e;
        rst_n = 1'b0;
        idle();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5);
        md_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'b00010);
            #2;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL reset_outs cyc=%0d got=%b exp=%b", i, obs, e); end
            n_cmp++;
            if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", i, stall_cnt); end
            @(negedge clk);
        end
        idle();
        rst_n = 1'b1;
        exp_q.push_back(5'b11000);
        #2;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_release got=%b exp=%b", obs, e); end
        n_cmp++;
        if (dbg_state !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b exp=00", dbg_state); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        logic [4:0] e;
        apply_reset();
        set_id(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b1, 5'd5);
        exp_q.push_back(5'b00010);
        #2;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL load_use_stall got=%b exp=%b", obs, e); end
        @(negedge clk);
        set_id(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0);
        exp_q.push_back(5'b11000);
        cnt_q.push_back(16'd1);
        #2;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL load_use_resume got=%b exp=%b", obs, e); end
        n_cmp++;
        if (stall_cnt !== cnt_q[0]) begin n_bad++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, cnt_q[0]); end
        void'(cnt_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_no_hazard();
        logic [4:0] e;
        logic [4:0] er, r1, r2;
        apply_reset();
        for (int p = 0; p < 14; p++) begin
            case (p)
                0: set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0);
                1: set_id(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7);
                2: set_id(1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7);
                11: set_id(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7);
                12: set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7);
                13: set_id(1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b1, 5'd7);
                default: begin
                    er = 5'($urandom_range(1, 31));
                    r1 = 5'((32'(er) + $urandom_range(1, 31)) % 32);
                    r2 = 5'((32'(er) + $urandom_range(1, 31)) % 32);
                    set_id(1'b1, r1, 1'b1, r2, 1'b1, 1'b1, er);
                end
            endcase
            exp_q.push_back((p == 11) ? 5'b00010 : 5'b11000);
            #2;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL no_hazard p=%0d rs=%0d rt=%0d ex_rt=%0d got=%b exp=%b", p, id_rs, id_rt, ex_rt, obs, e); end
            @(negedge clk);
        end
        cnt_q.push_back(16'd1);
        #2;
        n_cmp++;
        if (stall_cnt !== cnt_q[0]) begin n_bad++; $display("FAIL no_hazard_cnt got=%0d exp=%0d", stall_cnt, cnt_q[0]); end
        void'(cnt_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_mult_div();
        logic [4:0] e;
        apply_reset();
        for (int t = 0; t < 9; t++) begin
            idle();
            id_valid = 1'b1;
            case (t)
                0: md_start = 1'b1;
                1, 2, 3, 4: hilo_read = 1'b1;
                5: begin md_start = 1'b1; branch_taken = 1'b1; end
                6: hilo_read = 1'b1;
                7, 8: md_start = 1'b1;
                default: ;
            endcase
            case (t)
                1, 2, 3, 8: exp_q.push_back(5'b00011);
                5:          exp_q.push_back(5'b11110);
                default:    exp_q.push_back(5'b11000);
            endcase
            #2;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL mult_div t=%0d got=%b exp=%b", t, obs, e); end
            if (t == 4) begin
                n_cmp++;
                if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL mult_div_cnt got=%0d exp=3", stall_cnt); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_flush();
        logic [4:0] e;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            idle();
            case (c)
                0, 1, 3: set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4);
                default: set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
            endcase
            branch_taken = (c == 1);
            case (c)
                1:       exp_q.push_back(5'b11110);
                2, 6:    exp_q.push_back(5'b11000);
                default: exp_q.push_back(5'b00010);
            endcase
            #2;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs2 !== e) begin n_bad++; $display("FAIL branch c=%0d got=%b exp=%b", c, obs2, e); end
            if (c == 1) begin
                n_cmp++;
                if (dbg_state2 !== 2'b10) begin n_bad++; $display("FAIL branch_ldwait got=%b exp=10", dbg_state2); end
            end
            if (c == 2) begin
                n_cmp++;
                if (dbg_state2 !== 2'b00) begin n_bad++; $display("FAIL branch_timer_clear got=%b exp=00", dbg_state2); end
                n_cmp++;
                if (stall_cnt2 !== 4'd1) begin n_bad++; $display("FAIL branch_cnt got=%0d exp=1", stall_cnt2); end
            end
            if (c == 6) begin
                n_cmp++;
                if (stall_cnt2 !== 4'd4) begin n_bad++; $display("FAIL ld3_cnt got=%0d exp=4", stall_cnt2); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] ec;
        apply_reset();
        set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6);
        for (int i = 0; i < 20; i++) begin
            cnt_q.push_back((i > 15) ? 16'd15 : 16'(i));
            #2;
            ec = cnt_q.pop_front();
            n_cmp++;
            if ({12'd0, stall_cnt2} !== ec) begin n_bad++; $display("FAIL saturate i=%0d got=%0d exp=%0d", i, stall_cnt2, ec); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] e;
        apply_reset();
        id_valid = 1'b1;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        idle();
        n_cmp++;
        if (md_busy !== 1'b1) begin n_bad++; $display("FAIL async_busy_before got=%b exp=1", md_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dbg_state !== 2'b00) begin n_bad++; $display("FAIL async_state got=%b exp=00", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        id_valid = 1'b1;
        hilo_read = 1'b1;
        exp_q.push_back(5'b11000);
        #2;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL async_after got=%b exp=%b", obs, e); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mult_div();
        test_branch_flush();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
